// File: rtl/sr_pkg.sv
// Shared definitions for the status register: flag bit positions, ALU op codes
// and the priority decode of the active-low op lines.
package sr_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_SUM,
    OP_SUB,
    OP_MUL,
    OP_DIV,
    OP_SHL,
    OP_SHR
  } op_e;

  // Lowest-numbered asserted line wins: SUM > SUB > MUL > DIV > SHL > SHR.
  function automatic op_e decode_op(input logic sum_n, input logic sub_n,
                                    input logic mul_n, input logic div_n,
                                    input logic shl_n, input logic shr_n);
    op_e op;
    op = OP_NONE;
    if (!sum_n)      op = OP_SUM;
    else if (!sub_n) op = OP_SUB;
    else if (!mul_n) op = OP_MUL;
    else if (!div_n) op = OP_DIV;
    else if (!shl_n) op = OP_SHL;
    else if (!shr_n) op = OP_SHR;
    return op;
  endfunction

endpackage

// File: rtl/sr_flag_stack.sv
// LIFO of W-bit entries, DEPTH deep; reads the top entry combinationally.
// Simultaneous push and pop is a no-op; blocked push/pop raise one-cycle pulses.
module sr_flag_stack #(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [LW-1:0] level_m1;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          push_only;
  logic          pop_only;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign push_only = push && !pop;
  assign pop_only  = pop && !push;
  assign overflow  = push_only && full;
  assign underflow = pop_only && empty;

  // Write index is only used when not full, so level < DEPTH fits in IW bits.
  assign level_m1 = level - LW'(1);
  assign wr_idx   = level[IW-1:0];
  assign rd_idx   = level_m1[IW-1:0];
  assign rdata    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (push_only && !full) begin
      mem[wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (push_only && !full) begin
      level <= level + LW'(1);
    end else if (pop_only && !empty) begin
      level <= level_m1;
    end
  end

endmodule

// File: rtl/status_reg_stack.sv
// ALU status register: latches the result, derives N/V/C/Z from the op decode,
// and saves/restores {result, flags} on a LIFO with a sticky overflow/underflow error.
module status_reg_stack
  import sr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             ISUMn,
  input  logic             ISUBn,
  input  logic             IMULn,
  input  logic             IDIVn,
  input  logic             ISHLn,
  input  logic             ISHRn,
  input  logic             ESRn,
  input  logic [WIDTH-1:0] Dsrin,
  input  logic             Cin,
  input  logic             Vin,
  input  logic             PUSHn,
  input  logic             POPn,
  output logic [WIDTH-1:0] Dout,
  output logic [3:0]       FLAGS,
  output logic [LW-1:0]    LEVEL,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ERR
);

  op_e              op;
  logic [3:0]       load_flags;
  logic [WIDTH+3:0] top_entry;
  logic             push_req;
  logic             pop_req;
  logic             restore;
  logic             load;
  logic             overflow;
  logic             underflow;

  assign op       = decode_op(ISUMn, ISUBn, IMULn, IDIVn, ISHLn, ISHRn);
  assign push_req = !PUSHn;
  assign pop_req  = !POPn;
  assign restore  = pop_req && !push_req && !EMPTY;
  // A lone pop request (even from an empty stack) suppresses the load.
  assign load     = !ESRn && !(pop_req && !push_req);

  always_comb begin
    load_flags         = FLAGS;
    load_flags[FLAG_Z] = (Dsrin == '0);
    load_flags[FLAG_N] = Dsrin[WIDTH-1];
    case (op)
      OP_SUM, OP_SUB: begin
        load_flags[FLAG_C] = Cin;
        load_flags[FLAG_V] = Vin;
      end
      OP_SHL, OP_SHR: begin
        load_flags[FLAG_C] = Cin;
        load_flags[FLAG_V] = 1'b0;
      end
      OP_MUL, OP_DIV: begin
        load_flags[FLAG_C] = 1'b0;
        load_flags[FLAG_V] = Vin;
      end
      default: ;
    endcase
  end

  sr_flag_stack #(
    .W     (WIDTH + 4),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (CLK),
    .rst_n     (RSTn),
    .push      (push_req),
    .pop       (pop_req),
    .wdata     ({Dout, FLAGS}),
    .rdata     (top_entry),
    .level     (LEVEL),
    .full      (FULL),
    .empty     (EMPTY),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Dout  <= '0;
      FLAGS <= '0;
      ERR   <= 1'b0;
    end else begin
      if (restore) begin
        {Dout, FLAGS} <= top_entry;
      end else if (load) begin
        Dout  <= Dsrin;
        FLAGS <= load_flags;
      end
      if (overflow || underflow) begin
        ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_status_reg_stack.sv
// Directed vectors with hand-computed results; a monitor pops expectations
// one cycle after each vector is applied and compares the registered outputs.
module tb_status_reg_stack;

  logic       CLK;
  logic       RSTn;
  logic       ISUMn, ISUBn, IMULn, IDIVn, ISHLn, ISHRn;
  logic       ESRn;
  logic [7:0] Dsrin;
  logic       Cin, Vin, PUSHn, POPn;
  logic [7:0] Dout;
  logic [3:0] FLAGS;
  logic [2:0] LEVEL;
  logic       FULL, EMPTY, ERR;

  typedef struct packed {
    logic [7:0] dout;
    logic [3:0] flags;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       err;
  } obs_t;

  localparam logic [5:0] NONE = 6'b111111;
  localparam logic [5:0] SUM  = 6'b011111;
  localparam logic [5:0] SUB  = 6'b101111;
  localparam logic [5:0] MUL  = 6'b110111;
  localparam logic [5:0] SHL  = 6'b111101;
  localparam logic [5:0] SHR  = 6'b111110;

  obs_t exp_q[$];
  int   id_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_id   = 0;

  status_reg_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .ISUMn (ISUMn),
    .ISUBn (ISUBn),
    .IMULn (IMULn),
    .IDIVn (IDIVn),
    .ISHLn (ISHLn),
    .ISHRn (ISHRn),
    .ESRn  (ESRn),
    .Dsrin (Dsrin),
    .Cin   (Cin),
    .Vin   (Vin),
    .PUSHn (PUSHn),
    .POPn  (POPn),
    .Dout  (Dout),
    .FLAGS (FLAGS),
    .LEVEL (LEVEL),
    .FULL  (FULL),
    .EMPTY (EMPTY),
    .ERR   (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic obs_t mk(input logic [7:0] dout, input logic [3:0] flags,
                              input logic [2:0] level, input logic full,
                              input logic empty, input logic err);
    obs_t o;
    o.dout  = dout;
    o.flags = flags;
    o.level = level;
    o.full  = full;
    o.empty = empty;
    o.err   = err;
    return o;
  endfunction

  function automatic obs_t cur_obs();
    return mk(Dout, FLAGS, LEVEL, FULL, EMPTY, ERR);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got dout=%h flags=%b level=%0d full=%b empty=%b err=%b, expected dout=%h flags=%b level=%0d full=%b empty=%b err=%b",
               name, got.dout, got.flags, got.level, got.full, got.empty, got.err,
               want.dout, want.flags, want.level, want.full, want.empty, want.err);
    end
  endtask

  task automatic idle();
    {ISUMn, ISUBn, IMULn, IDIVn, ISHLn, ISHRn} = NONE;
    ESRn  = 1'b1;
    Dsrin = 8'h00;
    Cin   = 1'b0;
    Vin   = 1'b0;
    PUSHn = 1'b1;
    POPn  = 1'b1;
  endtask

  task automatic apply(input logic [5:0] ops, input logic esr_n, input logic [7:0] d,
                       input logic cin, input logic vin, input logic push_n,
                       input logic pop_n, input obs_t want);
    @(negedge CLK);
    {ISUMn, ISUBn, IMULn, IDIVn, ISHLn, ISHRn} = ops;
    ESRn  = esr_n;
    Dsrin = d;
    Cin   = cin;
    Vin   = vin;
    PUSHn = push_n;
    POPn  = pop_n;
    vec_id++;
    exp_q.push_back(want);
    id_q.push_back(vec_id);
  endtask

  // Monitor: outputs are registered, so each vector's result is visible just after the next edge.
  initial begin
    obs_t w;
    int   id;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        w  = exp_q.pop_front();
        id = id_q.pop_front();
        check($sformatf("vec%0d", id), cur_obs(), w);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d pending expectations, required 0", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    RSTn = 1'b1;
    #1 RSTn = 1'b0;
    #2 check("reset", cur_obs(), mk(8'h00, 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0));
    @(negedge CLK);
    RSTn = 1'b1;

    // Flag derivation
    apply(SUM,       1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, mk(8'h00, 4'b0011, 3'd0, 1'b0, 1'b1, 1'b0));
    apply(SUB,       1'b0, 8'h84, 1'b0, 1'b1, 1'b1, 1'b1, mk(8'h84, 4'b1100, 3'd0, 1'b0, 1'b1, 1'b0));
    apply(SUM,       1'b1, 8'h09, 1'b1, 1'b1, 1'b1, 1'b1, mk(8'h84, 4'b1100, 3'd0, 1'b0, 1'b1, 1'b0));
    apply(MUL,       1'b0, 8'h10, 1'b1, 1'b1, 1'b1, 1'b1, mk(8'h10, 4'b0100, 3'd0, 1'b0, 1'b1, 1'b0));
    apply(NONE,      1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, mk(8'h00, 4'b0101, 3'd0, 1'b0, 1'b1, 1'b0));
    apply(6'b010111, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, mk(8'hFF, 4'b1010, 3'd0, 1'b0, 1'b1, 1'b0));
    apply(SHL,       1'b0, 8'h40, 1'b1, 1'b1, 1'b1, 1'b1, mk(8'h40, 4'b0010, 3'd0, 1'b0, 1'b1, 1'b0));
    apply(6'b111010, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1, 1'b1, mk(8'h80, 4'b1100, 3'd0, 1'b0, 1'b1, 1'b0));

    // Stack round trip
    apply(SUM,  1'b0, 8'h07, 1'b1, 1'b0, 1'b1, 1'b1, mk(8'h07, 4'b0010, 3'd0, 1'b0, 1'b1, 1'b0));
    apply(NONE, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, mk(8'h07, 4'b0010, 3'd1, 1'b0, 1'b0, 1'b0));
    apply(SHR,  1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1, mk(8'h04, 4'b0000, 3'd2, 1'b0, 1'b0, 1'b0));
    apply(NONE, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, mk(8'h07, 4'b0010, 3'd1, 1'b0, 1'b0, 1'b0));
    apply(NONE, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, mk(8'h07, 4'b0010, 3'd0, 1'b0, 1'b1, 1'b0));

    // Fill with distinct entries, then overflow
    apply(SUM,  1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, mk(8'h11, 4'b0000, 3'd1, 1'b0, 1'b0, 1'b0));
    apply(SUM,  1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, mk(8'h22, 4'b0010, 3'd2, 1'b0, 1'b0, 1'b0));
    apply(SUB,  1'b0, 8'h83, 1'b0, 1'b1, 1'b0, 1'b1, mk(8'h83, 4'b1100, 3'd3, 1'b0, 1'b0, 1'b0));
    apply(NONE, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, mk(8'h00, 4'b0101, 3'd4, 1'b1, 1'b0, 1'b0));
    apply(NONE, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, mk(8'h00, 4'b0101, 3'd4, 1'b1, 1'b0, 1'b1));
    apply(NONE, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, mk(8'h83, 4'b1100, 3'd3, 1'b0, 1'b0, 1'b1));
    apply(NONE, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, mk(8'h22, 4'b0010, 3'd2, 1'b0, 1'b0, 1'b1));
    apply(SUM,  1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, mk(8'h55, 4'b0000, 3'd2, 1'b0, 1'b0, 1'b1));
    apply(SUM,  1'b0, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, mk(8'h11, 4'b0000, 3'd1, 1'b0, 1'b0, 1'b1));
    apply(NONE, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, mk(8'h07, 4'b0010, 3'd0, 1'b0, 1'b1, 1'b1));
    apply(NONE, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, mk(8'h07, 4'b0010, 3'd0, 1'b0, 1'b1, 1'b1));

    // Asynchronous reset between edges
    @(negedge CLK);
    idle();
    #2 RSTn = 1'b0;
    #1 check("async_reset", cur_obs(), mk(8'h00, 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0));
    @(negedge CLK);
    RSTn = 1'b1;

    apply(NONE, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, mk(8'h00, 4'b0000, 3'd0, 1'b0, 1'b1, 1'b0));
    apply(SUM,  1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, mk(8'h00, 4'b0000, 3'd0, 1'b0, 1'b1, 1'b1));

    @(negedge CLK);
    idle();
    repeat (3) @(negedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked expectations, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
